// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the three-operand 8-bit calculator and its
// operand sequencer front end.
//   WIDTH   : operand / result width in bits
//   OP_W    : op field width (low bits of the fourth byte of a transaction)
//   OP_*    : op encodings understood by the calculator
//   state_t : sequencer FSM states
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int WIDTH = 8;
  localparam int OP_W  = 2;

  localparam logic [OP_W-1:0] OP_ADD   = 2'b00;  // a + b + c
  localparam logic [OP_W-1:0] OP_NEG_A = 2'b01;  // -a + b + c
  localparam logic [OP_W-1:0] OP_NEG_B = 2'b10;  // a - b + c
  localparam logic [OP_W-1:0] OP_NEG_C = 2'b11;  // a + b - c

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_C    = 3'd2,
    S_OP   = 3'd3,
    S_EVAL = 3'd4,
    S_RES  = 3'd5
  } state_t;

  // Load states are the ones that take a byte from upstream.
  function automatic logic is_load_state(input state_t s);
    return (s == S_A) || (s == S_B) || (s == S_C) || (s == S_OP);
  endfunction

endpackage

// File: rtl/calc_operand_sequencer.sv
// -----------------------------------------------------------------------------
// calc_operand_sequencer
// Front end that turns the free-running combinational calculator into a
// transaction unit. Four bytes (A, B, C, op) arrive over a valid/ready
// stream, are held on the calculator inputs, the combinational result is
// sampled once, and {res, carry} is returned over a second valid/ready stream.
//
// Ports
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   clear            : synchronous abort of the current transaction
//   in_valid/in_ready/in_data   : upstream byte stream (A, B, C, op)
//   calc_a/b/c/op    : operands driven to the external calculator
//   calc_res/cout    : combinational calculator result and carry
//   out_valid/out_ready/out_res/out_carry : downstream result stream
//   busy             : high whenever the FSM is not in S_A
//   dbg_state        : current FSM state, for observation only
//
// Handshake rule (both streams): a transfer happens only on a rising clock
// edge where valid && ready. in_ready and out_valid depend on registered
// state only (plus rst_n forcing in_ready low), never on in_valid/out_ready.
// -----------------------------------------------------------------------------
module calc_operand_sequencer
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] calc_a,
  output logic [WIDTH-1:0] calc_b,
  output logic [WIDTH-1:0] calc_c,
  output logic [OP_W-1:0]  calc_op,
  input  logic [WIDTH-1:0] calc_res,
  input  logic             calc_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_carry,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [OP_W-1:0]  r_op;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;

  logic             w_load;

  assign w_load = is_load_state(r_state);

  // rst_n gates in_ready so upstream never sees a transfer during reset.
  assign in_ready  = rst_n & w_load;
  assign out_valid = (r_state == S_RES);
  assign busy      = (r_state != S_A);
  assign dbg_state = r_state;

  // Operands go straight from the registers; they only change when a new
  // byte is loaded into the corresponding register.
  assign calc_a    = r_a;
  assign calc_b    = r_b;
  assign calc_c    = r_c;
  assign calc_op   = r_op;
  assign out_res   = r_res;
  assign out_carry = r_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_op    <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
    end else if (clear) begin
      // Abort wins over everything, including a same-cycle result handshake.
      // Operand and result registers are left as they are.
      r_state <= S_A;
    end else begin
      case (r_state)
        S_A: begin
          if (in_valid) begin
            r_a     <= in_data;
            r_state <= S_B;
          end
        end
        S_B: begin
          if (in_valid) begin
            r_b     <= in_data;
            r_state <= S_C;
          end
        end
        S_C: begin
          if (in_valid) begin
            r_c     <= in_data;
            r_state <= S_OP;
          end
        end
        S_OP: begin
          if (in_valid) begin
            r_op    <= in_data[OP_W-1:0];
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          // Operands have been stable on the calculator for a full cycle.
          r_res   <= calc_res;
          r_carry <= calc_cout;
          r_state <= S_RES;
        end
        S_RES: begin
          if (out_ready) begin
            r_state <= S_A;
          end
        end
        default: r_state <= S_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_operand_sequencer
// Directed bench for calc_operand_sequencer with a behavioural calculator
// stub (negate selected operand, 3-way add mod 256, carry = bit 8).
// Expected results are hand-computed constants pushed onto exp_q.
// -----------------------------------------------------------------------------
module tb_calc_operand_sequencer;
  import calc_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] calc_a;
  logic [7:0] calc_b;
  logic [7:0] calc_c;
  logic [1:0] calc_op;
  logic [7:0] calc_res;
  logic       calc_cout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_res;
  logic       out_carry;
  logic       busy;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int xfer_before;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  calc_operand_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .calc_a    (calc_a),
    .calc_b    (calc_b),
    .calc_c    (calc_c),
    .calc_op   (calc_op),
    .calc_res  (calc_res),
    .calc_cout (calc_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_carry (out_carry),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- calculator stub ----------------
  logic [7:0] m_a, m_b, m_c;
  logic [9:0] m_sum;
  always_comb begin
    m_a = (calc_op == 2'b01) ? (8'd0 - calc_a) : calc_a;
    m_b = (calc_op == 2'b10) ? (8'd0 - calc_b) : calc_b;
    m_c = (calc_op == 2'b11) ? (8'd0 - calc_c) : calc_c;
    m_sum = {2'b00, m_a} + {2'b00, m_b} + {2'b00, m_c};
    calc_res  = m_sum[7:0];
    calc_cout = m_sum[8];
  end

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: a result transfer is seen at the negedge before the edge
  // that completes it; clear suppresses the transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !clear) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_result", {23'd0, out_carry, out_res}, 32'h1ff);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {23'd0, out_carry, out_res}, {23'd0, mon_exp});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 just after the byte is taken.
  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("in_ready_wait", {31'd0, (n < 50)}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] d);
    int g;
    g = $urandom_range(0, 4);
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    send_byte(d);
  endtask

  task automatic send_txn(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] op, input bit gaps);
    if (gaps) begin
      send_gap(a); send_gap(b); send_gap(c); send_gap(op);
    end else begin
      send_byte(a); send_byte(b); send_byte(c); send_byte(op);
    end
  endtask

  // Returns at a negedge where out_valid is high (or the bound expired).
  task automatic wait_out_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("out_valid_wait", {31'd0, (n < 20)}, 32'd1);
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, S_A});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    realign();

    // 1. Async reset in the middle of S_C
    send_byte(8'h11);
    send_byte(8'h22);
    check("t1_in_s_c", {29'd0, dbg_state}, {29'd0, S_C});
    in_valid = 1'b1;
    in_data  = 8'h33;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t1_state", {29'd0, dbg_state}, {29'd0, S_A});
    check("t1_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("t1_out_valid", {31'd0, out_valid}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_calc_a_cleared", {24'd0, calc_a}, 32'h00);
    @(posedge clk);
    #1;
    check("t1_in_ready_held", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("t1_in_ready_release", {31'd0, in_ready}, 32'd1);
    realign();

    // 2. Back-to-back 01,02,03,00 -> 0x06; first byte after reset is A
    exp_q.push_back(9'h006);
    send_txn(8'h01, 8'h02, 8'h03, 8'h00, 1'b0);
    @(negedge clk);
    check("t2_eval_no_valid", {31'd0, out_valid}, 32'd0);
    check("t2_eval_in_ready", {31'd0, in_ready}, 32'd0);
    check("t2_calc_a", {24'd0, calc_a}, 32'h01);
    check("t2_calc_b", {24'd0, calc_b}, 32'h02);
    check("t2_calc_c", {24'd0, calc_c}, 32'h03);
    check("t2_calc_op", {30'd0, calc_op}, 32'd0);
    @(negedge clk);
    check("t2_valid_t2", {31'd0, out_valid}, 32'd1);
    check("t2_res", {24'd0, out_res}, 32'h06);
    @(negedge clk);
    check("t2_valid_one_cycle", {31'd0, out_valid}, 32'd0);
    check("t2_busy_idle", {31'd0, busy}, 32'd0);
    realign();

    // 3. 05,0A,03,FE (op=10) with out_ready low 5 cycles; next A held back
    out_ready = 1'b0;
    exp_q.push_back(9'h0FE);
    send_txn(8'h05, 8'h0A, 8'h03, 8'hFE, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h80;
    check("t3_eval_in_ready", {31'd0, in_ready}, 32'd0);
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t3_hold_res", {24'd0, out_res}, 32'hFE);
      check("t3_hold_carry", {31'd0, out_carry}, 32'd0);
      check("t3_hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("t3_calc_op", {30'd0, calc_op}, 32'd2);
      if (i < 4) @(negedge clk);
    end
    realign();
    xfer_before = xfer_cnt;
    out_ready = 1'b1;
    exp_q.push_back(9'h120);
    send_byte(8'h80);
    check("t3_single_xfer", xfer_cnt, xfer_before + 1);
    check("t3_held_byte_is_a", {24'd0, calc_a}, 32'h80);
    send_byte(8'h90);
    send_byte(8'h10);
    send_byte(8'h00);
    wait_out_valid();
    realign();

    // 4. Random gaps between bytes
    exp_q.push_back(9'h006);
    send_txn(8'h01, 8'h02, 8'h03, 8'h00, 1'b1);
    wait_out_valid();
    realign();
    exp_q.push_back(9'h100);
    send_txn(8'h10, 8'h20, 8'h30, 8'hFF, 1'b1);
    check("t4_calc_op", {30'd0, calc_op}, 32'd3);
    wait_out_valid();
    realign();
    check("t4_queue_drained", exp_q.size(), 32'd0);

    // 5. clear in S_OP together with in_valid
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    check("t5_in_s_op", {29'd0, dbg_state}, {29'd0, S_OP});
    in_valid = 1'b1;
    in_data  = 8'h01;
    clear    = 1'b1;
    realign();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("t5_state", {29'd0, dbg_state}, {29'd0, S_A});
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_op_kept", {30'd0, calc_op}, 32'd3);
    check("t5_c_kept", {24'd0, calc_c}, 32'hCC);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_valid", {31'd0, out_valid}, 32'd0);
    end
    realign();
    exp_q.push_back(9'h000);
    send_txn(8'h01, 8'hFF, 8'h02, 8'h41, 1'b0);
    check("t5_op_low_bits", {30'd0, calc_op}, 32'd1);
    wait_out_valid();
    realign();

    // 6. clear and out_ready together in S_RES
    out_ready = 1'b0;
    send_txn(8'h05, 8'h06, 8'h07, 8'h00, 1'b0);
    wait_out_valid();
    check("t6_res_before_clear", {24'd0, out_res}, 32'h12);
    realign();
    xfer_before = xfer_cnt;
    clear     = 1'b1;
    out_ready = 1'b1;
    realign();
    clear = 1'b0;
    @(negedge clk);
    check("t6_valid_dropped", {31'd0, out_valid}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_state", {29'd0, dbg_state}, {29'd0, S_A});
    check("t6_no_xfer", xfer_cnt, xfer_before);
    realign();

    // Final report
    check("final_queue_empty", exp_q.size(), 32'd0);
    check("final_xfer_count", xfer_cnt, 32'd6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
